// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and constants for the tiled convolution layer
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2
    } state_e;

    // Width of every loop counter; comfortably covers any practical map/kernel size.
    localparam int CNT_W = 16;

endpackage

// File: rtl/cnn_pe.sv
// rtl/cnn_pe.sv - Tm x Tn combinational shortreal multiply-accumulate array
module cnn_pe #(
    parameter int TM_P = 2,
    parameter int TN_P = 2
) (
    input  shortreal x_i    [TN_P],
    input  shortreal w_i    [TM_P][TN_P],
    output shortreal psum_o [TM_P]
);

    // Each output lane sums its Tn products in ascending tn order so rounding is reproducible.
    always_comb begin
        for (int tm = 0; tm < TM_P; tm++) begin
            psum_o[tm] = 0.0;
            for (int tn = 0; tn < TN_P; tn++) begin
                psum_o[tm] = psum_o[tm] + w_i[tm][tn] * x_i[tn];
            end
        end
    end

endmodule

// File: rtl/cnn.sv
// rtl/cnn.sv - tiled convolution layer: FSM, loop nest, padding mux, accumulators
module cnn
    import cnn_pkg::*;
#(
    parameter int N_p  = 4,
    parameter int M_p  = 4,
    parameter int K_p  = 2,
    parameter int R_p  = 4,
    parameter int C_p  = 4,
    parameter int S_p  = 1,
    parameter int Tn_p = 2,
    parameter int Tm_p = 2
) (
    input  shortreal fm_i      [N_p][R_p][C_p],
    input  shortreal weights_i [M_p][N_p][K_p][K_p],
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     valid_i,
    output shortreal fm_o      [M_p][R_p][C_p]
);

    if (N_p < 1 || M_p < 1 || K_p < 1 || R_p < 1 || C_p < 1 || S_p < 1 ||
        Tn_p < 1 || Tm_p < 1) begin : g_bad_param
        $error("cnn: every parameter must be at least 1");
    end
    if ((M_p % Tm_p) != 0 || (N_p % Tn_p) != 0) begin : g_bad_tile
        $error("cnn: M_p must be a multiple of Tm_p and N_p a multiple of Tn_p");
    end

    localparam logic [CNT_W-1:0] MO_LAST = CNT_W'(M_p / Tm_p - 1);
    localparam logic [CNT_W-1:0] NO_LAST = CNT_W'(N_p / Tn_p - 1);
    localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(R_p - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(C_p - 1);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(K_p - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mo_q, mo_d, no_q, no_d, r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
    logic             start;

    shortreal fm_q  [N_p][R_p][C_p];
    shortreal w_q   [M_p][N_p][K_p][K_p];
    shortreal acc_q [M_p][R_p][C_p];
    shortreal acc_d [M_p][R_p][C_p];

    shortreal x_tile [Tn_p];
    shortreal w_tile [Tm_p][Tn_p];
    shortreal psum   [Tm_p];

    // Next state and loop-nest advance: j innermost, then i, c, r, no, mo outermost.
    always_comb begin
        state_d = state_q;
        mo_d    = mo_q;
        no_d    = no_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    start   = 1'b1;
                    state_d = COMPUTE;
                    mo_d = '0; no_d = '0; r_d = '0; c_d = '0; i_d = '0; j_d = '0;
                end
            end
            COMPUTE: begin
                if (j_q != K_LAST) begin
                    j_d = j_q + 1'b1;
                end else begin
                    j_d = '0;
                    if (i_q != K_LAST) begin
                        i_d = i_q + 1'b1;
                    end else begin
                        i_d = '0;
                        if (c_q != C_LAST) begin
                            c_d = c_q + 1'b1;
                        end else begin
                            c_d = '0;
                            if (r_q != R_LAST) begin
                                r_d = r_q + 1'b1;
                            end else begin
                                r_d = '0;
                                if (no_q != NO_LAST) begin
                                    no_d = no_q + 1'b1;
                                end else begin
                                    no_d = '0;
                                    if (mo_q != MO_LAST) begin
                                        mo_d = mo_q + 1'b1;
                                    end else begin
                                        mo_d    = '0;
                                        state_d = WRITE;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gather the Tn input samples for this step; rows/cols past the map edge select nothing and stay 0.0.
    always_comb begin
        for (int tn = 0; tn < Tn_p; tn++) begin
            x_tile[tn] = 0.0;
            for (int n = 0; n < N_p; n++) begin
                for (int rr = 0; rr < R_p; rr++) begin
                    for (int cc = 0; cc < C_p; cc++) begin
                        if (n == int'(no_q) * Tn_p + tn &&
                            rr == int'(r_q) * S_p + int'(i_q) &&
                            cc == int'(c_q) * S_p + int'(j_q)) begin
                            x_tile[tn] = fm_q[n][rr][cc];
                        end
                    end
                end
            end
        end
    end

    // Gather the Tm x Tn kernel taps at (i,j) for the current output/input tile pair.
    always_comb begin
        for (int tm = 0; tm < Tm_p; tm++) begin
            for (int tn = 0; tn < Tn_p; tn++) begin
                w_tile[tm][tn] = 0.0;
                for (int m = 0; m < M_p; m++) begin
                    for (int n = 0; n < N_p; n++) begin
                        for (int ii = 0; ii < K_p; ii++) begin
                            for (int jj = 0; jj < K_p; jj++) begin
                                if (m == int'(mo_q) * Tm_p + tm &&
                                    n == int'(no_q) * Tn_p + tn &&
                                    ii == int'(i_q) && jj == int'(j_q)) begin
                                    w_tile[tm][tn] = w_q[m][n][ii][jj];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    cnn_pe #(
        .TM_P (Tm_p),
        .TN_P (Tn_p)
    ) u_pe (
        .x_i    (x_tile),
        .w_i    (w_tile),
        .psum_o (psum)
    );

    // Accumulator update: cleared on start, one Tm-wide partial sum added per compute step.
    always_comb begin
        acc_d = acc_q;
        for (int m = 0; m < M_p; m++) begin
            for (int rr = 0; rr < R_p; rr++) begin
                for (int cc = 0; cc < C_p; cc++) begin
                    if (start) begin
                        acc_d[m][rr][cc] = 0.0;
                    end else if (state_q == COMPUTE && m / Tm_p == int'(mo_q) &&
                                 rr == int'(r_q) && cc == int'(c_q)) begin
                        acc_d[m][rr][cc] = acc_q[m][rr][cc] + psum[m % Tm_p];
                    end
                end
            end
        end
    end

    // State, counters, accumulators, latched operands and the output register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mo_q <= '0; no_q <= '0; r_q <= '0; c_q <= '0; i_q <= '0; j_q <= '0;
            for (int m = 0; m < M_p; m++)
                for (int rr = 0; rr < R_p; rr++)
                    for (int cc = 0; cc < C_p; cc++) begin
                        acc_q[m][rr][cc] <= 0.0;
                        fm_o[m][rr][cc]  <= 0.0;
                    end
            for (int n = 0; n < N_p; n++)
                for (int rr = 0; rr < R_p; rr++)
                    for (int cc = 0; cc < C_p; cc++)
                        fm_q[n][rr][cc] <= 0.0;
            for (int m = 0; m < M_p; m++)
                for (int n = 0; n < N_p; n++)
                    for (int ii = 0; ii < K_p; ii++)
                        for (int jj = 0; jj < K_p; jj++)
                            w_q[m][n][ii][jj] <= 0.0;
        end else begin
            state_q <= state_d;
            mo_q <= mo_d; no_q <= no_d; r_q <= r_d; c_q <= c_d; i_q <= i_d; j_q <= j_d;
            acc_q   <= acc_d;
            if (start) begin
                fm_q <= fm_i;
                w_q  <= weights_i;
            end
            if (state_q == WRITE) begin
                fm_o <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_cnn.sv
// tb/tb_cnn.sv - directed self-checking bench for the tiled convolution layer
module tb_cnn;
    import cnn_pkg::*;

    localparam int N = 4, M = 4, K = 2, R = 4, C = 4;
    localparam int STEPS = 256;

    shortreal fm      [N][R][C];
    shortreal weights [M][N][K][K];
    shortreal fm_out  [M][R][C];
    shortreal exp_fm  [M][R][C];
    logic     clk, reset, valid;

    int n_vec = 0;
    int n_bad = 0;

    cnn dut (
        .fm_i      (fm),
        .weights_i (weights),
        .clk_i     (clk),
        .reset_i   (reset),
        .valid_i   (valid),
        .fm_o      (fm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (%f), expected %h (%f)", tag, obs, $bitstoreal(obs),
                     exp, $bitstoreal(exp));
        end
    endtask

    task automatic check_fm(input string tag);
        for (int m = 0; m < M; m++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    check_vec($sformatf("%s[%0d][%0d][%0d]", tag, m, r, c),
                              $realtobits(real'(fm_out[m][r][c])),
                              $realtobits(real'(exp_fm[m][r][c])));
    endtask

    task automatic check_state(input string tag, input state_e exp);
        check_vec(tag, 64'(dut.state_q), 64'(exp));
    endtask

    task automatic set_exp_zero();
        for (int m = 0; m < M; m++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    exp_fm[m][r][c] = 0.0;
    endtask

    task automatic set_weights(input shortreal v);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        weights[m][n][i][j] = v;
    endtask

    task automatic set_identity();
        set_weights(0.0);
        for (int m = 0; m < M; m++) weights[m][m][0][0] = 1.0;
    endtask

    task automatic set_fm_const(input shortreal v);
        for (int n = 0; n < N; n++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    fm[n][r][c] = v;
    endtask

    // Quarter-step values in [0,63.75] are exact in shortreal.
    task automatic set_fm_random();
        for (int n = 0; n < N; n++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    fm[n][r][c] = shortreal'($urandom_range(0, 255)) / 4.0;
    endtask

    // Pulse valid across one rising edge (edge E); returns #1 after E.
    task automatic start_run();
        @(negedge clk);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        set_fm_const(0.0);
        set_weights(0.0);
        wait_edges(2);
        set_exp_zero();
        check_fm("reset_fm_o");
        check_state("reset_state", IDLE);
        @(negedge clk);
        reset = 1'b0;

        // All-ones run with a stray valid pulse and fm_i corruption mid-run.
        set_weights(1.0);
        set_fm_const(1.0);
        start_run();
        wait_edges(9);
        @(negedge clk);
        valid = 1'b1;
        set_fm_const(5.0);
        set_weights(3.0);
        @(posedge clk);
        #1 valid = 1'b0;
        check_state("busy_state", COMPUTE);
        wait_edges(STEPS - 10);
        set_exp_zero();
        check_fm("latency_hold");
        check_state("latency_state", WRITE);
        wait_edges(1);
        for (int m = 0; m < M; m++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    exp_fm[m][r][c] = (r < 3 && c < 3) ? 16.0 : ((r == 3 && c == 3) ? 4.0 : 8.0);
        check_fm("ones");
        check_state("ones_done_state", IDLE);
        wait_edges(1);
        check_state("no_restart_state", IDLE);

        // Zero kernel on random maps.
        set_weights(0.0);
        set_fm_random();
        start_run();
        wait_edges(STEPS + 1);
        set_exp_zero();
        check_fm("zero_w");

        // Identity kernel reproduces input map m on output m.
        set_identity();
        set_fm_random();
        exp_fm = fm;
        start_run();
        wait_edges(STEPS + 1);
        check_fm("identity");

        // Reset at E+100 aborts the run and zeroes the output immediately.
        set_fm_random();
        start_run();
        wait_edges(99);
        @(negedge clk);
        reset = 1'b1;
        #1;
        set_exp_zero();
        check_fm("abort_fm_o");
        check_state("abort_state", IDLE);
        @(negedge clk);
        reset = 1'b0;
        exp_fm = fm;
        start_run();
        wait_edges(STEPS + 1);
        check_fm("after_abort");
        check_state("after_abort_state", IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
